// File: rtl/mac_pkg.sv
// Shared types and constants for the windowed multiply-accumulate sink.
package mac_pkg;

    localparam int unsigned WIDTH_IN_DEF  = 8;
    localparam int unsigned WIDTH_ACC_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mac_state_e;

    // Signed max (neg=0) or min (neg=1) of a w-bit value, in the low w bits.
    function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
        logic [63:0] lim;
        lim = (64'd1 << (w - 1)) - 64'd1;
        if (neg) begin
            lim = ~lim;
        end
        return lim;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed adder with overflow flag; saturates on overflow when MAC_SAT_EN is defined,
// otherwise wraps modulo 2^W.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int unsigned W = WIDTH_ACC_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_c,
    output logic                ovf_c
);

    logic signed [W-1:0] raw;

    // Overflow when both operands share a sign the wrapped sum does not.
    always_comb begin
        raw   = a + b;
        ovf_c = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef MAC_SAT_EN
        sum_c = ovf_c ? W'(sat_limit(W, a[W-1])) : raw;
`else
        sum_c = raw;
`endif
    end

endmodule

// File: rtl/mac_window_acc.sv
// Windowed multiply-accumulate sink: accumulates signed a*b products, closes a
// window on each tick and offers the window sum on a valid/ready result port.
// Build option: MAC_SAT_EN selects saturating instead of wrapping accumulation.
module mac_window_acc
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH_IN  = WIDTH_IN_DEF,
    parameter int unsigned WIDTH_ACC = WIDTH_ACC_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic                        clr_i,
    input  logic                        tick_i,
    input  logic signed [WIDTH_IN-1:0]  a_i,
    input  logic signed [WIDTH_IN-1:0]  b_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic signed [WIDTH_ACC-1:0] res_o,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic                        ovf_o
);

    localparam int unsigned PROD_W = 2 * WIDTH_IN;

    mac_state_e                  state_q, state_d;
    logic signed [WIDTH_ACC-1:0] acc_q, acc_d;
    logic                        wovf_q, wovf_d;
    logic signed [WIDTH_ACC-1:0] res_d;
    logic                        res_valid_d;
    logic                        ovf_d;
    logic                        in_ready_d;

    logic                        fire;
    logic                        port_free;
    logic signed [PROD_W-1:0]    prod;
    logic signed [WIDTH_ACC-1:0] prod_ext;
    logic signed [WIDTH_ACC-1:0] addend;
    logic signed [WIDTH_ACC-1:0] sum_c;
    logic                        add_ovf_c;

    // Full-width signed product, sign-extended into the accumulator width.
    assign fire     = in_valid_i && in_ready_o;
    assign prod     = PROD_W'(a_i) * PROD_W'(b_i);
    assign prod_ext = WIDTH_ACC'(prod);
    assign addend   = fire ? prod_ext : '0;

    mac_sat_add #(
        .W (WIDTH_ACC)
    ) u_add (
        .a     (acc_q),
        .b     (addend),
        .sum_c (sum_c),
        .ovf_c (add_ovf_c)
    );

    // Next state, accumulator and result-port updates; clr > tick > fire.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wovf_d      = wovf_q;
        res_d       = res_o;
        res_valid_d = res_valid_o;
        ovf_d       = ovf_o;
        port_free   = !res_valid_o || res_ready_i;

        if (res_valid_o && res_ready_i) begin
            res_valid_d = 1'b0;
        end

        if (clr_i) begin
            acc_d       = '0;
            wovf_d      = 1'b0;
            res_valid_d = 1'b0;
            ovf_d       = 1'b0;
            state_d     = en_i ? ACC : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (tick_i && port_free) begin
                        // Same-cycle fire belongs to the closing window.
                        res_d       = sum_c;
                        ovf_d       = wovf_q | add_ovf_c;
                        res_valid_d = 1'b1;
                        acc_d       = '0;
                        wovf_d      = 1'b0;
                        state_d     = en_i ? ACC : IDLE;
                    end else begin
                        acc_d  = sum_c;
                        wovf_d = wovf_q | add_ovf_c;
                        if (tick_i) begin
                            state_d = HOLD;
                        end else if (!en_i) begin
                            state_d = IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready_i) begin
                        res_d       = acc_q;
                        ovf_d       = wovf_q;
                        res_valid_d = 1'b1;
                        acc_d       = '0;
                        wovf_d      = 1'b0;
                        state_d     = en_i ? ACC : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        in_ready_d = (state_d == ACC);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            wovf_q      <= 1'b0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
            in_ready_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            wovf_q      <= wovf_d;
            res_o       <= res_d;
            res_valid_o <= res_valid_d;
            ovf_o       <= ovf_d;
            in_ready_o  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_mac_window_acc.sv
// Self-checking bench for mac_window_acc: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model using wide integers.
module tb_mac_window_acc;

    localparam int unsigned W_IN  = 8;
    localparam int unsigned W_ACC = 24;
    localparam int S_IDLE = 0;
    localparam int S_ACC  = 1;
    localparam int S_HOLD = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en_i = 1'b0;
    logic                    clr_i = 1'b0;
    logic                    tick_i = 1'b0;
    logic signed [W_IN-1:0]  a_i = '0;
    logic signed [W_IN-1:0]  b_i = '0;
    logic                    in_valid_i = 1'b0;
    logic                    res_ready_i = 1'b0;
    logic                    in_ready_o;
    logic signed [W_ACC-1:0] res_o;
    logic                    res_valid_o;
    logic                    ovf_o;

    logic                    r16_in_ready;
    logic signed [15:0]      r16_res;
    logic                    r16_valid;
    logic                    r16_ovf;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int     m_st;
    longint m_acc;
    bit     m_wovf;
    longint m_res;
    bit     m_valid;
    bit     m_ovf;
    bit     m_rdy;

    mac_window_acc #(
        .WIDTH_IN  (W_IN),
        .WIDTH_ACC (W_ACC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .tick_i      (tick_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .ovf_o       (ovf_o)
    );

    mac_window_acc #(
        .WIDTH_IN  (W_IN),
        .WIDTH_ACC (16)
    ) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .tick_i      (tick_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (r16_in_ready),
        .res_o       (r16_res),
        .res_valid_o (r16_valid),
        .res_ready_i (res_ready_i),
        .ovf_o       (r16_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reduce an exact sum into the accumulator range: wrap or saturate.
    function automatic longint fold(input longint s, input int w, output bit o);
        longint hi;
        longint lo;
        longint span;
        span = longint'(1) <<< w;
        hi   = (longint'(1) <<< (w - 1)) - 1;
        lo   = -hi - 1;
        o    = (s > hi) || (s < lo);
        if (!o) return s;
`ifdef MAC_SAT_EN
        return (s > hi) ? hi : lo;
`else
        s = s % span;
        if (s > hi) s -= span;
        if (s < lo) s += span;
        return s;
`endif
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_acc = 0; m_wovf = 0; m_res = 0;
        m_valid = 0; m_ovf = 0; m_rdy = 0;
    endtask

    task automatic model_cycle(input bit en, input bit clr, input bit tick,
                               input bit vld, input bit rdy, input int a, input int b);
        bit     fire;
        bit     room;
        bit     o;
        longint s;
        fire = vld && m_rdy;
        room = !m_valid || rdy;
        s    = fold(m_acc + (fire ? longint'(a) * longint'(b) : 0), W_ACC, o);
        if (m_valid && rdy) m_valid = 0;
        if (clr) begin
            m_acc = 0; m_wovf = 0; m_valid = 0; m_ovf = 0;
            m_st = en ? S_ACC : S_IDLE;
        end else if (m_st == S_ACC) begin
            if (tick && room) begin
                m_res = s; m_ovf = m_wovf | o; m_valid = 1;
                m_acc = 0; m_wovf = 0; m_st = en ? S_ACC : S_IDLE;
            end else begin
                m_acc = s; m_wovf = m_wovf | o;
                if (tick) m_st = S_HOLD;
                else if (!en) m_st = S_IDLE;
            end
        end else if (m_st == S_HOLD) begin
            if (rdy) begin
                m_res = m_acc; m_ovf = m_wovf; m_valid = 1;
                m_acc = 0; m_wovf = 0; m_st = en ? S_ACC : S_IDLE;
            end
        end else if (en) begin
            m_st = S_ACC;
        end
        m_rdy = (m_st == S_ACC);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, longint'(res_valid_o), longint'(m_valid));
        check({tag, ".ready"}, longint'(in_ready_o), longint'(m_rdy));
        check({tag, ".ovf"},   longint'(ovf_o), longint'(m_ovf));
        check({tag, ".res"},   longint'(res_o), m_res);
    endtask

    task automatic step(input string tag, input bit en, input bit clr, input bit tick,
                        input bit vld, input bit rdy, input int a, input int b);
        en_i = en; clr_i = clr; tick_i = tick; in_valid_i = vld; res_ready_i = rdy;
        a_i = W_IN'(a); b_i = W_IN'(b);
        model_cycle(en, clr, tick, vld, rdy, a, b);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int     a;
        int     b;
        int     sel;
        longint exp16;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Periodic tick, 3x4 every cycle, consumer always ready.
        step("w12_clr", 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step("w12", 1, 0, (i % 3) == 2, 1, 1, 3, 4);
            if ((i % 3) == 2) begin
                check("w12_sum", longint'(res_o), 36);
                check("w12_pulse", longint'(res_valid_o), 1);
            end else begin
                check("w12_idle", longint'(res_valid_o), 0);
            end
        end

        // Fire on the tick cycle belongs to the closing window.
        step("neg_clr", 1, 1, 0, 0, 1, 0, 0);
        step("neg_a", 1, 0, 0, 1, 1, -5, 7);
        step("neg_b", 1, 0, 1, 1, 1, 2, 2);
        check("neg_sum", longint'(res_o), -31);
        step("neg_next", 1, 0, 1, 0, 1, 0, 0);
        check("neg_fresh", longint'(res_o), 0);

        // Blocked consumer: first result held, HOLD entered, second tick dropped.
        step("hold_clr", 1, 1, 0, 0, 0, 0, 0);
        step("hold_t1", 1, 0, 1, 1, 0, 1, 1);
        step("hold_f", 1, 0, 0, 1, 0, 2, 2);
        step("hold_t2", 1, 0, 1, 1, 0, 3, 3);
        check("hold_ready_low", longint'(in_ready_o), 0);
        step("hold_t3", 1, 0, 1, 1, 0, 9, 9);
        check("hold_stable", longint'(res_o), 1);
        step("hold_go", 1, 0, 0, 0, 1, 0, 0);
        check("hold_xfer", longint'(res_o), 13);
        step("hold_done", 1, 0, 0, 0, 1, 0, 0);

        // 16-bit accumulator overflow with 127*127 fires.
        step("o16_clr", 1, 1, 0, 0, 1, 0, 0);
        step("o16_1", 1, 0, 0, 1, 1, 127, 127);
        step("o16_2", 1, 0, 0, 1, 1, 127, 127);
        step("o16_3", 1, 0, 1, 1, 1, 127, 127);
`ifdef MAC_SAT_EN
        exp16 = 32767;
`else
        exp16 = 48387 - 65536;
`endif
        check("o16_res", longint'(r16_res), exp16);
        check("o16_ovf", longint'(r16_ovf), 1);
        check("o16_valid", longint'(r16_valid), 1);

        // clr beats tick and fire.
        step("clr_pre", 1, 0, 0, 1, 1, 5, 5);
        step("clr_all", 1, 1, 1, 1, 1, 6, 6);
        check("clr_novalid", longint'(res_valid_o), 0);
        step("clr_post", 1, 0, 1, 0, 1, 0, 0);
        check("clr_zero", longint'(res_o), 0);

        // Asynchronous reset mid-window and mid-HOLD.
        step("rst_w", 1, 0, 0, 1, 1, 7, 7);
        async_reset_check("rst_mid_window");
        step("rst_h0", 1, 0, 0, 0, 0, 0, 0);
        step("rst_h1", 1, 0, 1, 1, 0, 2, 3);
        step("rst_h2", 1, 0, 1, 1, 0, 4, 5);
        async_reset_check("rst_mid_hold");

        // Randomized mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            a = int'($urandom_range(255)) - 128;
            b = int'($urandom_range(255)) - 128;
            step("rnd", $urandom_range(99) < 92, $urandom_range(99) < 3,
                 $urandom_range(99) < 20, $urandom_range(99) < 75,
                 $urandom_range(99) < 70, a, b);
        end

        // Long windows of large same-sign products to drive overflow.
        step("ovf_clr", 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(9));
            a = (sel < 5) ? 127 : -128;
            b = (sel < 5) ? 127 : -128;
            if (sel == 9) b = 1;
            step("ovf", 1, 0, (i % 700) == 699, 1, $urandom_range(99) < 90, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_window_acc.md
Name: mac_window_acc

Overview:
- Multiply-accumulate sink driven by the periodic `ready_o` tick of `counter`.
- Each accepted operand pair (a_i × b_i, signed) is added to a running accumulator.
- Each tick closes the current window. The window sum is presented downstream on a valid/ready result port, and a fresh window starts.
- Sits between the operand source and the result consumer. `counter` supplies the window timing; this block consumes that timing.

Parameters:
- WIDTH_IN, 8, signed width of each operand a_i/b_i.
- WIDTH_ACC, 24, signed accumulator/result width (must be ≥ 2*WIDTH_IN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_i  input  1  block enable; low = IDLE.
- clr_i  input  1  synchronous clear of accumulator and flags.
- tick_i  input  1  window-close pulse, connected to counter ready_o.
- a_i  input  WIDTH_IN  signed operand A.
- b_i  input  WIDTH_IN  signed operand B.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block can accept operands.
- res_o  output  WIDTH_ACC  signed window sum.
- res_valid_o  output  1  res_o valid.
- res_ready_i  input  1  downstream accepts res_o.
- ovf_o  output  1  overflow occurred in the window currently shown on res_o.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, res_o=0, res_valid_o=0, ovf_o=0, in_ready_o=0, internal ovf flag=0.
- Operand fire: in_valid_i && in_ready_o. The product is full-width signed (2*WIDTH_IN), sign-extended to WIDTH_ACC, then added to acc at the clock edge (1-cycle latency to acc).
- Overflow: signed overflow of the add sets a sticky internal ovf flag for the current window.

State machine:
- IDLE (en_i=0):
  - in_ready_o=0.
  - tick_i is ignored.
  - acc is retained.
  - The result port still completes any pending handshake.
  - Go to ACC when en_i=1.
- ACC:
  - in_ready_o=1.
  - On tick_i with the result port free (res_valid_o=0, or res_ready_i=1 in the same cycle):
    - res_o <= acc + product of any same-cycle fire (that fire is included in the closing window).
    - ovf_o <= window ovf.
    - res_valid_o <= 1.
    - acc <= 0, internal ovf <= 0.
    - Stay in ACC.
  - On tick_i with the result port blocked: go to HOLD. A same-cycle fire is still added to acc.
  - en_i=0: go to IDLE.
- HOLD:
  - in_ready_o=0.
  - acc frozen; further tick_i are dropped.
  - When res_ready_i=1: perform the window transfer above, then go to ACC (or IDLE if en_i=0).
- Result handshake: res_valid_o is held with res_o stable until res_ready_i. It clears the cycle after acceptance unless a new window loads in the same cycle.
- Priority in one cycle: clr_i > tick_i > operand fire.
  - clr_i clears acc, internal ovf, res_valid_o and ovf_o.
  - clr_i returns HOLD to ACC.
- Reset mid-window: all state is lost, with no partial result emitted.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: the accumulator saturates to the signed max/min of WIDTH_ACC on overflow. ovf_o still reports saturation.
- Undefined: the accumulator wraps modulo 2^WIDTH_ACC. ovf_o reports that wrap occurred.

Decomposition:
- Package mac_pkg:
  - state enum typedef (IDLE, ACC, HOLD).
  - default width constants.
  - saturating-limit helper function.
- Sub-module mac_sat_add (combinational signed add with overflow flag and optional saturation, gated by MAC_SAT_EN).

Test Plan:
- counter with interrupt_num_i=2 drives tick_i; operands a=3, b=4 fire every cycle; res_ready_i=1 → each res_o equals 12 × (operands accepted in the window), and res_valid_o pulses once per tick.
- Operands (-5,7) then (2,2), tick in the same cycle as the second fire → res_o = -31, next window starts at 0.
- res_ready_i=0 across two ticks → first result held stable; HOLD entered; second tick dropped; in_ready_o=0; on res_ready_i=1 the held acc transfers next cycle.
- WIDTH_ACC=16, repeated 127×127 fires → without MAC_SAT_EN res_o wraps and ovf_o=1; with MAC_SAT_EN res_o=32767 and ovf_o=1.
- clr_i asserted together with tick_i and a fire → acc=0, res_valid_o=0, no result emitted.
- rst_n pulsed low mid-window and mid-HOLD → all outputs return to 0 asynchronously, state IDLE.
